// File: rtl/tis_core_pkg.sv
// tis_core_pkg: shared constants, opcodes and value saturation for the TIS execution core.
package tis_core_pkg;
  localparam int PROG_DEPTH = 15;
  localparam int INSTR_W = 16;
  localparam int DATA_W = 11;
  localparam int VAL_MAX = 999;
  localparam int SRC_FLAG_BIT = 11;
  localparam int SRC_REG_BIT = 0;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_MOV_ACC, OP_MOV_NIL, OP_SWP, OP_SAV, OP_ADD, OP_SUB,
    OP_NEG, OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ, OP_JRO
  } opcode_t;
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [DATA_W:0] v);
    return v > VAL_MAX ? DATA_W'(VAL_MAX) : v < -VAL_MAX ? DATA_W'(-VAL_MAX) : v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/tis_exec_core_hex.sv
// hex_to_7seg: hex digit to active-low seven-segment code (bits g..a).
module hex_to_7seg (
  input  logic [3:0] hexval,
  output logic [6:0] ledcode
);
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  assign ledcode = GLYPH[hexval];
endmodule

// File: rtl/tis_exec_core.sv
// tis_exec_core: single-node TIS-100-style core retiring one instruction per clock.
// Define TIS_CORE_HEX_EN to add seven-segment debug outputs for pc and acc.
module tis_exec_core
  import tis_core_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               pLength,
  input  logic [INSTR_W-1:0]       prog [0:PROG_DEPTH-1],
  output logic [3:0]               pc,
  output logic signed [DATA_W-1:0] acc,
  output logic signed [DATA_W-1:0] bak
`ifdef TIS_CORE_HEX_EN
  ,
  output logic [6:0]               hex_pc,
  output logic [6:0]               hex_acc_hi,
  output logic [6:0]               hex_acc_lo
`endif
);
  logic [3:0] len, op, pc_inc, jmp_pc, jro_pc, pc_nxt;
  logic [INSTR_W-1:0] ins;
  logic signed [DATA_W-1:0] src, acc_nxt, bak_nxt;
  logic signed [DATA_W:0] jro_sum;
  logic taken;
  assign len = pLength > 4'(PROG_DEPTH) ? 4'(PROG_DEPTH) : pLength;
  assign ins = prog[pc];
  assign op = ins[15:12];
  always_comb begin
    src = ins[SRC_FLAG_BIT] ? (ins[SRC_REG_BIT] ? '0 : acc) : saturate({ins[DATA_W-1], ins[DATA_W-1:0]});
    taken = op == OP_JMP || (op == OP_JEZ && acc == 0) || (op == OP_JNZ && acc != 0) ||
            (op == OP_JGZ && acc > 0) || (op == OP_JLZ && acc < 0);
    pc_inc = ({1'b0, pc} + 5'd1 >= {1'b0, len}) ? 4'd0 : pc + 4'd1;
    jmp_pc = ins[3:0] >= len ? 4'd0 : ins[3:0];
    jro_sum = {{(DATA_W-3){1'b0}}, pc} + {src[DATA_W-1], src};
    jro_pc = jro_sum < 0 ? 4'd0 :
             jro_sum >= $signed({{(DATA_W-3){1'b0}}, len}) ? len - 4'd1 : jro_sum[3:0];
    // A shrunken program length pulls a stranded pc back to slot 0.
    pc_nxt = pc >= len ? 4'd0 : op == OP_JRO ? jro_pc : taken ? jmp_pc : pc_inc;
    acc_nxt = op == OP_MOV_ACC ? src :
              op == OP_SWP     ? bak :
              op == OP_ADD     ? saturate({acc[DATA_W-1], acc} + {src[DATA_W-1], src}) :
              op == OP_SUB     ? saturate({acc[DATA_W-1], acc} - {src[DATA_W-1], src}) :
              op == OP_NEG     ? -acc : acc;
    bak_nxt = (op == OP_SWP || op == OP_SAV) ? acc : bak;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      acc <= '0;
      bak <= '0;
    end else if (len != 4'd0) begin
      pc <= pc_nxt;
      acc <= acc_nxt;
      bak <= bak_nxt;
    end
  end
`ifdef TIS_CORE_HEX_EN
  hex_to_7seg u_hex_pc (.hexval(pc), .ledcode(hex_pc));
  hex_to_7seg u_hex_hi (.hexval(acc[7:4]), .ledcode(hex_acc_hi));
  hex_to_7seg u_hex_lo (.hexval(acc[3:0]), .ledcode(hex_acc_lo));
`endif
endmodule

// File: tb/tb_tis_exec_core.sv
// tb_tis_exec_core: directed self-checking bench for tis_exec_core (hex checks under TIS_CORE_HEX_EN).
module tb_tis_exec_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] pLength = 4'd0;
  logic [15:0] prog [0:14];
  logic [3:0] pc;
  logic signed [10:0] acc, bak;
  int vectors = 0;
  int miscompares = 0;
`ifdef TIS_CORE_HEX_EN
  logic [6:0] hex_pc, hex_acc_hi, hex_acc_lo;
`endif
  tis_exec_core dut (
    .clk(clk), .rst(rst), .pLength(pLength), .prog(prog),
    .pc(pc), .acc(acc), .bak(bak)
`ifdef TIS_CORE_HEX_EN
    , .hex_pc(hex_pc), .hex_acc_hi(hex_acc_hi), .hex_acc_lo(hex_acc_lo)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] imm(input logic [3:0] op, input int v);
    return {op, 1'b0, 11'(v)};
  endfunction
  function automatic logic [15:0] rg(input logic [3:0] op, input logic nil);
    return {op, 1'b1, 10'd0, nil};
  endfunction
  function automatic logic [15:0] jp(input logic [3:0] op, input logic [3:0] t);
    return {op, 8'd0, t};
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask
  task automatic restart(input logic [3:0] len);
    rst = 1'b1;
    pLength = len;
    for (int i = 0; i < 15; i++) prog[i] = 16'h0000;
  endtask
  int ep[], ea[], eb[];
  initial begin
    restart(4'd4);
    #1;
    chk("reset_pc", pc, 0);
    chk("reset_acc", acc, 0);
    chk("reset_bak", bak, 0);
    prog[0] = imm(4'h1, 5);
    prog[1] = imm(4'h5, 1);
    prog[2] = 16'h4000;
    prog[3] = rg(4'h6, 1'b0);
    step(1);
    rst = 1'b0;
    ep = '{1, 2, 3, 0, 1};
    ea = '{5, 6, 6, 0, 5};
    eb = '{0, 0, 6, 6, 6};
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("loop_pc%0d", i), pc, ep[i]);
      chk($sformatf("loop_acc%0d", i), acc, ea[i]);
      chk($sformatf("loop_bak%0d", i), bak, eb[i]);
    end
    rst = 1'b1;
    #2;
    chk("async_pc", pc, 0);
    chk("async_acc", acc, 0);
    chk("async_bak", bak, 0);
    restart(4'd7);
    prog[0] = imm(4'h1, 990);
    prog[1] = imm(4'h5, 20);
    prog[2] = imm(4'h6, 999);
    prog[3] = imm(4'h6, 999);
    prog[4] = 16'h7000;
    prog[5] = imm(4'h1, -1024);
    prog[6] = imm(4'h6, 1023);
    step(1);
    rst = 1'b0;
    ep = '{1, 2, 3, 4, 5, 6, 0};
    ea = '{990, 999, 0, -999, 999, -999, -999};
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk($sformatf("sat_pc%0d", i), pc, ep[i]);
      chk($sformatf("sat_acc%0d", i), acc, ea[i]);
    end
    restart(4'd8);
    prog[0] = jp(4'h9, 4'd3);
    prog[1] = jp(4'hC, 4'd6);
    prog[2] = jp(4'h8, 4'd9);
    prog[3] = imm(4'h1, 1);
    prog[4] = jp(4'h9, 4'd7);
    prog[5] = jp(4'hB, 4'd7);
    prog[6] = jp(4'hA, 4'd2);
    prog[7] = imm(4'h1, -1);
    step(1);
    rst = 1'b0;
    ep = '{3, 4, 5, 7, 0, 1, 6, 2, 0, 1};
    ea = '{0, 1, 1, 1, -1, -1, -1, -1, -1, -1};
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("jmp_pc%0d", i), pc, ep[i]);
      chk($sformatf("jmp_acc%0d", i), acc, ea[i]);
    end
    restart(4'd5);
    prog[2] = imm(4'hD, 10);
    prog[4] = imm(4'hD, -7);
    step(1);
    rst = 1'b0;
    ep = '{1, 2, 4, 0, 1};
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("jro_pc%0d", i), pc, ep[i]);
    end
    prog[2] = imm(4'hD, 0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk($sformatf("jro0_pc%0d", i), pc, 2);
    end
    restart(4'd0);
    prog[0] = imm(4'h1, 5);
    prog[1] = 16'h4000;
    step(1);
    rst = 1'b0;
    step(3);
    chk("len0_pc", pc, 0);
    chk("len0_acc", acc, 0);
    chk("len0_bak", bak, 0);
    restart(4'd8);
    prog[5] = imm(4'h1, 7);
    step(1);
    rst = 1'b0;
    step(5);
    chk("shrink_pre_pc", pc, 5);
    pLength = 4'd2;
    step(1);
    chk("shrink_pc", pc, 0);
    chk("shrink_acc", acc, 7);
`ifdef TIS_CORE_HEX_EN
    restart(4'd1);
    prog[0] = imm(4'h1, 58);
    step(1);
    rst = 1'b0;
    step(1);
    chk("hex_acc", acc, 58);
    chk("hex_pc", hex_pc, 7'b1000000);
    chk("hex_hi", hex_acc_hi, 7'b0110000);
    chk("hex_lo", hex_acc_lo, 7'b0001000);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
